// File: rtl/wb_trigger_multi.sv
// wb_trigger_multi
//   Multi-channel periodic trigger generator with a Wishbone slave port.
//   Each channel produces a pulse train: high for WIDTH out of every PERIOD
//   cycles, optionally stopping after one period (one-shot).
//
// Parameters
//   NCH    number of trigger channels (1..8)
//   CNT_W  width of the period/width counters (2..32)
//
// Ports
//   clk        single rising-edge clock
//   reset      synchronous, active-high reset
//   wb_stb_i   Wishbone strobe
//   wb_cyc_i   Wishbone cycle
//   wb_we_i    Wishbone write enable
//   wb_ack_o   Wishbone acknowledge (one-cycle pulse)
//   wb_adr_i   Wishbone byte address (word index taken from bits [7:2])
//   wb_sel_i   Wishbone byte-lane selects
//   wb_dat_i   Wishbone write data
//   wb_dat_o   Wishbone read data, registered, valid while wb_ack_o is high
//   trig_o     per-channel trigger outputs, registered
//
// Register map (word index = wb_adr_i[7:2])
//   0x00 CTRL     [NCH-1:0] EN, [8+NCH-1:8] ONESHOT, [31] RESTART (write-only)
//   0x04 STATUS   [NCH-1:0] RUN, [8+NCH-1:8] DONE (write-1-to-clear)
//   0x10+8n PERIOD_n, 0x14+8n WIDTH_n (pending values)
module wb_trigger_multi #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wb_stb_i,
  input  logic           wb_cyc_i,
  input  logic           wb_we_i,
  output logic           wb_ack_o,
  input  logic [31:0]    wb_adr_i,
  input  logic [3:0]     wb_sel_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  output logic [NCH-1:0] trig_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NCH-1:0]   en;
  logic [NCH-1:0]   oneshot;
  logic [NCH-1:0]   run;
  logic [NCH-1:0]   done;
  logic [CNT_W-1:0] pend_p [NCH];
  logic [CNT_W-1:0] pend_w [NCH];
  logic [CNT_W-1:0] act_p  [NCH];
  logic [CNT_W-1:0] act_w  [NCH];
  logic [CNT_W-1:0] cnt    [NCH];
  logic [CNT_W-1:0] cnt_next [NCH];

  logic           access;
  logic           req;
  logic           wr;
  logic [5:0]     widx;
  logic [31:0]    lane_mask;
  logic [31:0]    ctrl_rd;
  logic [31:0]    status_rd;
  logic [31:0]    rd_data;
  logic           ctrl_wr;
  logic           status_wr;
  logic           restart;
  logic [NCH-1:0] en_new;
  logic [NCH-1:0] os_new;
  logic [NCH-1:0] done_clr;
  logic [NCH-1:0] ch_start;
  logic [NCH-1:0] ch_stop;
  logic [NCH-1:0] ch_wrap;
  logic [NCH-1:0] ch_finish;
  logic           unused_adr;

  // Merge write data into a counter-width register honouring byte lanes;
  // lanes beyond CNT_W simply fall off in the truncation.
  function automatic logic [CNT_W-1:0] merge_cnt(input logic [CNT_W-1:0] old_val,
                                                 input logic [31:0]      wdat,
                                                 input logic [31:0]      mask);
    return CNT_W'((32'(old_val) & ~mask) | (wdat & mask));
  endfunction

  // Only the first access cycle (ack still low) is serviced, so a held
  // strobe yields ack on alternate cycles.
  assign access     = wb_stb_i & wb_cyc_i;
  assign req        = access & ~wb_ack_o;
  assign wr         = req & wb_we_i;
  assign widx       = wb_adr_i[7:2];
  assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

  assign ctrl_wr   = wr && (widx == 6'd0);
  assign status_wr = wr && (widx == 6'd1);
  assign restart   = ctrl_wr && wb_sel_i[3] && wb_dat_i[31];
  assign en_new    = wb_sel_i[0] ? wb_dat_i[NCH-1:0]  : en;
  assign os_new    = wb_sel_i[1] ? wb_dat_i[8 +: NCH] : oneshot;
  assign done_clr  = {NCH{status_wr & wb_sel_i[1]}} & wb_dat_i[8 +: NCH];

  // Byte-lane mask and read multiplexer for the register map
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{wb_sel_i[i]}};
    end
    ctrl_rd              = '0;
    ctrl_rd[NCH-1:0]     = en;
    ctrl_rd[8 +: NCH]    = oneshot;
    status_rd            = '0;
    status_rd[NCH-1:0]   = run;
    status_rd[8 +: NCH]  = done;
    rd_data = '0;
    if (widx == 6'd0) begin
      rd_data = ctrl_rd;
    end else if (widx == 6'd1) begin
      rd_data = status_rd;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (widx == 6'(4 + 2*n)) rd_data = 32'(pend_p[n]);
        if (widx == 6'(5 + 2*n)) rd_data = 32'(pend_w[n]);
      end
    end
  end

  // Per-channel control events. A disable write beats everything, a start
  // beats a wrap, so one-shot completion only counts when neither happens.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      ch_start[n]  = ctrl_wr && en_new[n] && (!en[n] || restart);
      ch_stop[n]   = ctrl_wr && !en_new[n];
      ch_wrap[n]   = run[n] && (act_p[n] != '0) && (cnt[n] == act_p[n] - CNT_ONE);
      cnt_next[n]  = ch_wrap[n] ? '0 : cnt[n] + CNT_ONE;
      ch_finish[n] = ch_wrap[n] && oneshot[n] && !ch_stop[n] && !ch_start[n];
    end
  end

  // Bus response, register writes and the channel counters. Active
  // PERIOD/WIDTH reload only at start and wrap so a mid-period write never
  // disturbs the period in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      en       <= '0;
      oneshot  <= '0;
      run      <= '0;
      done     <= '0;
      trig_o   <= '0;
      for (int n = 0; n < NCH; n++) begin
        pend_p[n] <= '0;
        pend_w[n] <= '0;
        act_p[n]  <= '0;
        act_w[n]  <= '0;
        cnt[n]    <= '0;
      end
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rd_data : '0;
      if (ctrl_wr) oneshot <= os_new;
      done <= (done & ~done_clr) | ch_finish;
      for (int n = 0; n < NCH; n++) begin
        if (wr && (widx == 6'(4 + 2*n))) pend_p[n] <= merge_cnt(pend_p[n], wb_dat_i, lane_mask);
        if (wr && (widx == 6'(5 + 2*n))) pend_w[n] <= merge_cnt(pend_w[n], wb_dat_i, lane_mask);
        if (ch_stop[n]) begin
          en[n]     <= 1'b0;
          run[n]    <= 1'b0;
          trig_o[n] <= 1'b0;
        end else if (ch_start[n]) begin
          en[n]     <= 1'b1;
          run[n]    <= 1'b1;
          cnt[n]    <= '0;
          act_p[n]  <= pend_p[n];
          act_w[n]  <= pend_w[n];
          trig_o[n] <= (pend_p[n] != '0) && (pend_w[n] != '0);
        end else if (ch_wrap[n]) begin
          cnt[n]   <= '0;
          act_p[n] <= pend_p[n];
          act_w[n] <= pend_w[n];
          if (oneshot[n]) begin
            en[n]     <= 1'b0;
            run[n]    <= 1'b0;
            trig_o[n] <= 1'b0;
          end else begin
            trig_o[n] <= (pend_p[n] != '0) && (pend_w[n] != '0);
          end
        end else if (run[n] && (act_p[n] != '0)) begin
          cnt[n]    <= cnt_next[n];
          trig_o[n] <= cnt_next[n] < act_w[n];
        end
      end
    end
  end

endmodule
